// File: rtl/gte_mac_lanes.sv
// gte_mac_lanes: N-lane operand-select multiply-accumulate with a valid/ready result stage.
// Define GTE_MAC_SAT_EN to clamp each lane result to OUT_W and report the clamp on o_ovf.
module gte_mac_lanes #(
    parameter int LANES = 3,
    parameter int IN_W  = 16,
    parameter int NSRC  = 8,
    parameter int ACC_W = 44,
    parameter int OUT_W = 32,
    parameter int SHIFT = 12,
    localparam int SW   = $clog2(NSRC)
) (
    input  logic                   i_clk,
    input  logic                   i_nRst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic                   i_sf,
    input  logic [NSRC*IN_W-1:0]   i_srcL,
    input  logic [NSRC*IN_W-1:0]   i_srcR,
    input  logic [LANES*SW-1:0]    i_selL,
    input  logic [LANES*SW-1:0]    i_selR,
    input  logic [LANES-1:0]       i_unsL,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*OUT_W-1:0] o_res,
    output logic [LANES-1:0]       o_ovf
);
    localparam int PW = 2 * IN_W + 3;

    logic stall, accept, update, load;
    logic v1_q, v1_d, first_q, first_d, last_q, last_d, sf_q, sf_d;
    logic open_q, open_d, valid_q, valid_d;
    logic [LANES-1:0][IN_W-1:0]  op_l, op_r;
    logic [LANES-1:0][IN_W:0]    l_q, l_d;
    logic [LANES-1:0][IN_W+1:0]  r_q, r_d;
    logic [LANES-1:0][PW-1:0]    prod;
    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d, acc_nx;
    logic [LANES-1:0][OUT_W-1:0] res_q, res_d, res_nx;
    logic [LANES-1:0]            ovf_q, ovf_d, ovf_nx;

    function automatic logic [IN_W-1:0] pick(input logic [NSRC*IN_W-1:0] bus, input logic [SW-1:0] sel);
        return (int'(sel) < NSRC) ? bus[int'(sel)*IN_W +: IN_W] : '0;
    endfunction

    // Returns {overflow, result} for one shifted lane sum.
    function automatic logic [OUT_W:0] clip(input logic [ACC_W-1:0] v);
`ifdef GTE_MAC_SAT_EN
        logic ovf;
        ovf = v[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){v[ACC_W-1]}};
        return {ovf, ovf ? {v[ACC_W-1], {(OUT_W-1){~v[ACC_W-1]}}} : v[OUT_W-1:0]};
`else
        return {1'b0, v[OUT_W-1:0]};
`endif
    endfunction

    assign stall  = valid_q & ~i_ready;
    assign o_ready = ~stall;
    assign accept = i_valid & ~stall;
    assign update = v1_q & ~stall;
    assign load   = update & last_q;

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            op_l[n]   = pick(i_srcL, i_selL[n*SW +: SW]);
            op_r[n]   = pick(i_srcR, i_selR[n*SW +: SW]);
            l_d[n]    = stall ? l_q[n] : {op_l[n][IN_W-1] & ~i_unsL[n], op_l[n]};
            r_d[n]    = stall ? r_q[n] : {{2{op_r[n][IN_W-1]}}, op_r[n]};
            prod[n]   = PW'($signed(l_q[n])) * PW'($signed(r_q[n]));
            acc_nx[n] = ((first_q | ~open_q) ? '0 : acc_q[n]) + {{(ACC_W-PW){prod[n][PW-1]}}, prod[n]};
            {ovf_nx[n], res_nx[n]} = clip(ACC_W'($signed(acc_nx[n]) >>> (sf_q ? SHIFT : 0)));
        end
        v1_d    = i_flush ? 1'b0 : stall ? v1_q : accept;
        first_d = stall ? first_q : i_first;
        last_d  = stall ? last_q : i_last;
        sf_d    = stall ? sf_q : i_sf;
        open_d  = i_flush ? 1'b0 : update ? ~last_q : open_q;
        acc_d   = i_flush ? '0 : update ? acc_nx : acc_q;
        valid_d = i_flush ? 1'b0 : stall ? valid_q : load;
        res_d   = i_flush ? '0 : load ? res_nx : res_q;
        ovf_d   = i_flush ? '0 : load ? ovf_nx : stall ? ovf_q : '0;
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            v1_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            sf_q    <= 1'b0;
            open_q  <= 1'b0;
            valid_q <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            first_q <= first_d;
            last_q  <= last_d;
            sf_q    <= sf_d;
            open_q  <= open_d;
            valid_q <= valid_d;
            l_q     <= l_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid = valid_q;
    assign o_res   = res_q;
    assign o_ovf   = ovf_q;
endmodule
